// File: rtl/sram_uart_tx_pkg.sv
// Shared types and constants for the SRAM-to-UART transmit path.
//
// Contents:
//   tx_ctrl_state_type - states of the word-fetch / byte-dispatch controller
//   tx_ser_state_type  - states of the byte serializer
//   DATA_BITS          - payload bits per UART frame
//   FRAME_BITS         - total bits per frame (start + data + [parity] + stop)
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> 11-bit frames with an even parity bit before the stop bit
//   undefined -> plain 8N1, 10-bit frames
package sram_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_FETCH,
    S_TX_WAIT,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_DRAIN,
    S_TX_DONE
  } tx_ctrl_state_type;

  typedef enum logic [2:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_PARITY,
    SER_STOP
  } tx_ser_state_type;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/sram_uart_tx_interface_uart_tx_byte.sv
// uart_tx_byte: serializes one byte per handshake as a UART frame.
//
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   tx_valid  in   a byte is offered on tx_data
//   tx_data   in   byte to send (sent LSB first)
//   tx_ready  out  serializer can take a byte on this edge
//   UART_TX_O out  serial line, idles high
//
// Configuration macro: UART_TX_PARITY_EN adds an even parity bit between
// data bit 7 and the stop bit.
//
// The line is a registered copy of the level implied by the current state,
// so it trails the state by one cycle. Every bit still lasts exactly
// CLKS_PER_BIT cycles, and accepting a new byte during the final stop-bit
// cycle makes the next start bit follow the stop bit with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       UART_TX_O
);

  import sram_uart_tx_pkg::*;

  tx_ser_state_type state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        line_q, line_d;
  logic        baud_last;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));

  // Ready when idle, or in the last cycle of the stop bit (the final frame
  // position) so a following byte chains without any idle bits.
  assign tx_ready  = (state_q == SER_IDLE) ||
                     ((state_q == SER_STOP) && baud_last &&
                      (bit_q == 4'(FRAME_BITS - 1)));
  assign accept    = tx_valid && tx_ready;
  assign UART_TX_O = line_q;

  // Next-state logic: bit_q tracks the position within the frame
  // (0 = start, 1..8 = data, then optional parity, then stop).
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      SER_START:  line_d = 1'b0;
      SER_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      SER_PARITY: line_d = parity_q;
`endif
      default:    line_d = 1'b1;
    endcase

    if (state_q != SER_IDLE) begin
      if (baud_last) begin
        baud_d = 16'd0;
        bit_d  = bit_q + 4'd1;
        case (state_q)
          SER_START: state_d = SER_DATA;
          SER_DATA: begin
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == 4'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
              state_d = SER_PARITY;
`else
              state_d = SER_STOP;
`endif
            end
          end
          SER_PARITY: state_d = SER_STOP;
          SER_STOP:   state_d = SER_IDLE;
          default:    state_d = SER_IDLE;
        endcase
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end

    if (accept) begin
      state_d  = SER_START;
      baud_d   = 16'd0;
      bit_d    = 4'd0;
      shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
      parity_d = ^tx_data;
`endif
    end
  end

  // State register; reset forces the line idle and abandons any frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SER_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 4'd0;
      shift_q  <= 8'd0;
      line_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: rtl/sram_uart_tx_interface.sv
// sram_uart_tx_interface: reads a block of 16-bit SRAM words and sends
// each word over UART as two frames, high byte first.
//
// Ports:
//   CLOCK_50_I     in   system clock (50 MHz)
//   reset          in   synchronous, active-high reset
//   Start          in   one-cycle pulse starting a transfer (ignored when busy)
//   Start_address  in   first word address, sampled with Start
//   Word_count     in   number of words, sampled with Start
//   SRAM_address   out  registered read address
//   SRAM_read_data in   read data from the SRAM controller
//   SRAM_we_n      out  tied high, this block only reads
//   UART_TX_O      out  serial line, idles high
//   Busy           out  transfer in progress
//   Done           out  one-cycle pulse after the last stop bit
//
// Configuration macro: UART_TX_PARITY_EN (passed through to the serializer).
module sram_uart_tx_interface #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int SRAM_READ_LAT = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  import sram_uart_tx_pkg::*;

  tx_ctrl_state_type state_q, state_d;
  logic [17:0] base_addr_q, base_addr_d;
  logic [17:0] count_q, count_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        ready_prev_q;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = (state_q == S_TX_DONE);

  // Controller. After the low byte of a word is accepted the next word is
  // fetched straight away, so it is ready long before the serializer asks
  // for it. The serializer is idle once tx_ready has been high for two
  // consecutive cycles: the first is the final stop-bit cycle, the second
  // is true idle.
  always_comb begin
    state_d     = state_q;
    base_addr_d = base_addr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    word_d      = word_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    tx_valid    = 1'b0;
    tx_data     = word_q[15:8];

    case (state_q)
      S_TX_IDLE: begin
        if (Start) begin
          base_addr_d = Start_address;
          count_d     = Word_count;
          state_d     = S_TX_FETCH;
        end
      end
      S_TX_FETCH: begin
        busy_d = 1'b1;
        if (count_q == 18'd0) begin
          state_d = S_TX_DRAIN;
        end else begin
          addr_d  = base_addr_q;
          wait_d  = 8'd0;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (wait_q == 8'(SRAM_READ_LAT - 1)) begin
          word_d  = SRAM_read_data;
          state_d = S_TX_SEND_HI;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_TX_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = word_q[15:8];
        if (tx_ready) state_d = S_TX_SEND_LO;
      end
      S_TX_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (tx_ready) begin
          if (count_q == 18'd1) begin
            state_d = S_TX_DRAIN;
          end else begin
            count_d = count_q - 18'd1;
            addr_d  = addr_q + 18'd1;
            wait_d  = 8'd0;
            state_d = S_TX_WAIT;
          end
        end
      end
      S_TX_DRAIN: begin
        if (tx_ready && ready_prev_q) begin
          busy_d  = 1'b0;
          state_d = S_TX_DONE;
        end
      end
      S_TX_DONE: state_d = S_TX_IDLE;
      default:   state_d = S_TX_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q      <= S_TX_IDLE;
      base_addr_q  <= 18'd0;
      count_q      <= 18'd0;
      addr_q       <= 18'd0;
      word_q       <= 16'd0;
      wait_q       <= 8'd0;
      busy_q       <= 1'b0;
      ready_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_addr_q  <= base_addr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      wait_q       <= wait_d;
      busy_q       <= busy_d;
      ready_prev_q <= tx_ready;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock    (CLOCK_50_I),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .UART_TX_O(UART_TX_O)
  );

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Self-checking bench for sram_uart_tx_interface with CLKS_PER_BIT=8.
// The expected line waveform is computed from the frame format: for the
// k-th cycle after the first falling edge, the byte index is k/frame_len
// and the bit within the frame is (k%frame_len)/8.
// Configuration macro: UART_TX_PARITY_EN enables the parity test.
module tb_sram_uart_tx_interface;

  localparam int CPB = 8;
  localparam int LAT = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC = FB * CPB;
  localparam int FIRST_FALL = LAT + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  logic [15:0] mem [262144];

  int n_cmp = 0;
  int n_bad = 0;

  logic        line_s[$];
  logic        busy_s[$];
  logic        we_s[$];
  logic [17:0] addr_s[$];
  logic [7:0]  expb[$];
  int          done_edge;
  int          done_cnt;

  always #5 clk = ~clk;

  // Synchronous SRAM: data for the address driven in one cycle is
  // available in the next and is latched by the DUT one edge later.
  always @(posedge clk) SRAM_read_data <= mem[SRAM_address];

  sram_uart_tx_interface #(
    .CLKS_PER_BIT (CPB),
    .SRAM_READ_LAT(LAT)
  ) dut (
    .CLOCK_50_I    (clk),
    .reset         (reset),
    .Start         (Start),
    .Start_address (Start_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_we_n     (SRAM_we_n),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  // Line level expected pos cycles into the frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int pos);
    int bitn;
    bitn = pos / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    if (FB == 11 && bitn == 9) return ^b;
    return 1'b1;
  endfunction

  // Number of cycles of frame idx that differ from the model.
  function automatic int byte_errs(input int idx);
    int errs;
    int n;
    errs = 0;
    for (int s = 0; s < FC; s++) begin
      n = FIRST_FALL + idx * FC + s;
      if (n >= line_s.size()) errs++;
      else if (line_s[n] !== exp_level(expb[idx], s)) errs++;
    end
    return errs;
  endfunction

  function automatic int first_fall();
    for (int n = 0; n < line_s.size(); n++)
      if (line_s[n] === 1'b0) return n;
    return -1;
  endfunction

  task automatic set_expected(input logic [17:0] a, input int c);
    logic [15:0] w;
    expb.delete();
    for (int i = 0; i < c; i++) begin
      w = mem[a + 18'(i)];
      expb.push_back(w[15:8]);
      expb.push_back(w[7:0]);
    end
  endtask

  // Starts a transfer (Start sampled at edge 0) and records outputs #1
  // after every edge. kind 1 injects a second Start at edge inj; kind 2
  // asserts reset for the edge after inj and stops recording there.
  task automatic run_xfer(input logic [17:0] a, input logic [17:0] c,
                          input int inj, input int kind);
    int budget;
    budget = 2 * int'(c) * FC + 40;
    line_s.delete(); busy_s.delete(); we_s.delete(); addr_s.delete();
    done_edge = -1;
    done_cnt  = 0;
    @(negedge clk);
    Start = 1'b1; Start_address = a; Word_count = c;
    @(posedge clk); #1;
    Start = 1'b0;
    line_s.push_back(UART_TX_O); busy_s.push_back(Busy);
    we_s.push_back(SRAM_we_n); addr_s.push_back(SRAM_address);
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      line_s.push_back(UART_TX_O); busy_s.push_back(Busy);
      we_s.push_back(SRAM_we_n); addr_s.push_back(SRAM_address);
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      if (kind == 2 && n == inj + 1) begin reset = 1'b0; break; end
      if (kind == 1 && n == inj) begin
        Start = 1'b1; Start_address = a + 18'd7; Word_count = c + 18'd1;
      end
      if (kind == 1 && n == inj + 1) Start = 1'b0;
      if (kind == 2 && n == inj) reset = 1'b1;
      if (done_edge >= 0 && n >= done_edge + 3) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (UART_TX_O !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_line: got %b expected 1", UART_TX_O); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", Done); end
    n_cmp++; if (SRAM_we_n !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_we_n: got %b expected 1", SRAM_we_n); end
    n_cmp++; if (SRAM_address !== 18'd0) begin n_bad++; $display("[TB] FAIL reset_addr: got %h expected 0", SRAM_address); end
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int ff;
    mem[100] = 16'hA55A;
    set_expected(18'd100, 1);
    run_xfer(18'd100, 18'd1, 0, 0);
    ff = first_fall();
    n_cmp++; if (busy_s[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_e0: got %b expected 0", busy_s[0]); end
    n_cmp++; if (busy_s[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy_e1: got %b expected 1", busy_s[1]); end
    n_cmp++; if (addr_s[1] !== 18'd100) begin n_bad++; $display("[TB] FAIL single_addr_e1: got %h expected %h", addr_s[1], 18'd100); end
    n_cmp++; if (ff !== FIRST_FALL) begin n_bad++; $display("[TB] FAIL single_first_fall: got %0d expected %0d", ff, FIRST_FALL); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL single_byte%0d: %0d bad cycles expected 0 (byte %h)", i, byte_errs(i), expb[i]); end
    end
    n_cmp++; if (done_edge - FIRST_FALL !== 2 * FC) begin n_bad++; $display("[TB] FAIL single_done_delay: got %0d expected %0d", done_edge - FIRST_FALL, 2 * FC); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cnt); end
    n_cmp++; if (done_edge < 0 || busy_s[done_edge] !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_at_done: done edge %0d, Busy not low expected 0", done_edge); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506;
    set_expected(18'd0, 3);
    run_xfer(18'd0, 18'd3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL b2b_byte%0d: %0d bad cycles expected 0 (byte %h)", i, byte_errs(i), expb[i]); end
    end
    gaps = 0;
    for (int j = 1; j < 6; j++)
      if (FIRST_FALL + j * FC >= line_s.size() || line_s[FIRST_FALL + j * FC] !== 1'b0) gaps++;
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("[TB] FAIL b2b_gapless: got %0d late start bits expected 0", gaps); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", done_cnt); end
    n_cmp++; if (done_edge !== FIRST_FALL + 6 * FC) begin n_bad++; $display("[TB] FAIL b2b_done_edge: got %0d expected %0d", done_edge, FIRST_FALL + 6 * FC); end
  endtask

  task automatic test_wrap();
    logic [17:0] next_addr;
    mem[18'h3FFFF] = 16'hBEEF; mem[0] = 16'hCAFE;
    set_expected(18'h3FFFF, 2);
    run_xfer(18'h3FFFF, 18'd2, 0, 0);
    next_addr = addr_s[addr_s.size() - 1];
    for (int n = 2; n < addr_s.size(); n++)
      if (addr_s[n] !== 18'h3FFFF) begin next_addr = addr_s[n]; break; end
    n_cmp++; if (addr_s[1] !== 18'h3FFFF) begin n_bad++; $display("[TB] FAIL wrap_addr0: got %h expected 3ffff", addr_s[1]); end
    n_cmp++; if (next_addr !== 18'h00000) begin n_bad++; $display("[TB] FAIL wrap_addr1: got %h expected 00000", next_addr); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL wrap_byte%0d: %0d bad cycles expected 0 (byte %h)", i, byte_errs(i), expb[i]); end
    end
  endtask

  task automatic test_zero_count();
    int lows;
    run_xfer(18'd5, 18'd0, 0, 0);
    lows = 0;
    foreach (line_s[n]) if (line_s[n] !== 1'b1) lows++;
    n_cmp++; if (done_edge !== 2) begin n_bad++; $display("[TB] FAIL zero_done_edge: got %0d expected 2", done_edge); end
    n_cmp++; if (busy_s[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL zero_busy_e1: got %b expected 1", busy_s[1]); end
    n_cmp++; if (busy_s[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_busy_e2: got %b expected 0", busy_s[2]); end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("[TB] FAIL zero_line_quiet: got %0d low cycles expected 0", lows); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_start_while_busy();
    logic [17:0] a;
    a = 18'($urandom);
    for (int i = 0; i < 12; i++) mem[a + 18'(i)] = 16'($urandom);
    set_expected(a, 2);
    run_xfer(a, 18'd2, 30, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL busy_start_byte%0d: %0d bad cycles expected 0 (byte %h)", i, byte_errs(i), expb[i]); end
    end
    n_cmp++; if (done_edge !== FIRST_FALL + 4 * FC) begin n_bad++; $display("[TB] FAIL busy_start_done_edge: got %0d expected %0d", done_edge, FIRST_FALL + 4 * FC); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_midframe();
    int ff;
    mem[200] = 16'hC35A;
    run_xfer(18'd200, 18'd1, 48, 2);
    // Edge 48 is inside data bit 4 of byte C3, which is 0.
    n_cmp++; if (line_s[48] !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_bit4: got %b expected 0", line_s[48]); end
    n_cmp++; if (line_s[49] !== 1'b1) begin n_bad++; $display("[TB] FAIL midreset_line: got %b expected 1", line_s[49]); end
    n_cmp++; if (busy_s[49] !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy_s[49]); end
    n_cmp++; if (we_s[49] !== 1'b1) begin n_bad++; $display("[TB] FAIL midreset_we_n: got %b expected 1", we_s[49]); end
    repeat (2) @(posedge clk);
    mem[201] = 16'($urandom);
    set_expected(18'd201, 1);
    run_xfer(18'd201, 18'd1, 0, 0);
    ff = first_fall();
    n_cmp++; if (ff !== FIRST_FALL) begin n_bad++; $display("[TB] FAIL restart_first_fall: got %0d expected %0d", ff, FIRST_FALL); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL restart_byte%0d: %0d bad cycles expected 0 (byte %h)", i, byte_errs(i), expb[i]); end
    end
    n_cmp++; if (done_edge !== FIRST_FALL + 2 * FC) begin n_bad++; $display("[TB] FAIL restart_done_edge: got %0d expected %0d", done_edge, FIRST_FALL + 2 * FC); end
  endtask

  task automatic test_random();
    logic [17:0] a;
    int c;
    for (int t = 0; t < 3; t++) begin
      a = 18'($urandom);
      c = int'($urandom_range(1, 2));
      for (int i = 0; i < c; i++) mem[a + 18'(i)] = 16'($urandom);
      set_expected(a, c);
      run_xfer(a, 18'(c), 0, 0);
      for (int i = 0; i < 2 * c; i++) begin
        n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL rand%0d_byte%0d: %0d bad cycles expected 0 (byte %h)", t, i, byte_errs(i), expb[i]); end
      end
      n_cmp++; if (done_edge !== FIRST_FALL + 2 * c * FC) begin n_bad++; $display("[TB] FAIL rand%0d_done_edge: got %0d expected %0d", t, done_edge, FIRST_FALL + 2 * c * FC); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int p0;
    int p1;
    mem[300] = 16'h0703;
    set_expected(18'd300, 1);
    run_xfer(18'd300, 18'd1, 0, 0);
    p0 = FIRST_FALL + 9 * CPB + CPB / 2;
    p1 = p0 + FC;
    n_cmp++; if (line_s[p0] !== 1'b1) begin n_bad++; $display("[TB] FAIL parity_07: got %b expected 1", line_s[p0]); end
    n_cmp++; if (line_s[p1] !== 1'b0) begin n_bad++; $display("[TB] FAIL parity_03: got %b expected 0", line_s[p1]); end
    n_cmp++; if (done_edge - FIRST_FALL !== 2 * 88) begin n_bad++; $display("[TB] FAIL parity_frame_len: got %0d expected %0d", done_edge - FIRST_FALL, 2 * 88); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (byte_errs(i) !== 0) begin n_bad++; $display("[TB] FAIL parity_byte%0d: %0d bad cycles expected 0", i, byte_errs(i)); end
    end
  endtask
`endif

  initial begin
    $display("[TB] starting sram_uart_tx_interface bench");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_reset_midframe();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_uart_tx_interface.md
Name: sram_uart_tx_interface

Overview:
- Transmit-side counterpart of the UART-to-SRAM receive path. Reads a block of 16-bit words from external SRAM and serializes each word over UART_TX_O as two 8N1 frames, high byte first.
- Lets the team dump decoded image data (e.g. the RGB segment at 146944) back to the host for checking.
- Sits beside the UART receive unit. The top FSM grants it the SRAM port while Busy=1.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud).
- SRAM_READ_LAT, 2, cycles from SRAM_address being driven to SRAM_read_data being valid.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle pulse that begins a transfer; ignored while Busy.
- Start_address  in  18  first SRAM word address; sampled together with Start.
- Word_count  in  18  number of words to send; sampled together with Start.
- SRAM_address  out  18  registered read address.
- SRAM_read_data  in  16  read data from the SRAM controller.
- SRAM_we_n  out  1  held at 1; this block never writes.
- UART_TX_O  out  1  serial line; idle level is 1.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  single-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, UART_TX_O=1, Busy=0, Done=0. FSM goes to S_TX_IDLE; bit and baud counters clear.
- Reset mid-frame: UART_TX_O returns to 1 on the next edge. The frame is truncated and not resumed.
- Controller FSM states:
  - S_TX_IDLE: waits for Start.
  - S_TX_FETCH: drives the address.
  - S_TX_WAIT: counts SRAM_READ_LAT cycles, then latches SRAM_read_data into a word register.
  - S_TX_SEND_HI: hands the high byte to the serializer.
  - S_TX_SEND_LO: hands the low byte to the serializer.
  - S_TX_DRAIN: waits for the serializer to go idle.
  - S_TX_DONE: pulses Done, returns to S_TX_IDLE.
- Start sampled at edge 0 with Word_count != 0:
  - Busy=1 and SRAM_address=Start_address after edge 1.
  - Data latched at edge 1+SRAM_READ_LAT.
  - UART_TX_O falls (first start bit) at edge SRAM_READ_LAT+3, which is edge 5 for defaults.
- Prefetch: when the serializer accepts the low byte of word k, the FSM fetches word k+1 (address+1) into the holding register. This gives back-to-back frames with no idle bits between any two bytes.
- Address increment is modulo 2^18; 18'h3FFFF wraps to 0.
- Word_count=0: Busy pulses for one cycle, Done pulses at edge 2, and UART_TX_O stays 1.
- A Start that arrives while Busy=1 is ignored and the latched parameters are unchanged.
- Frame format:
  - One start bit (0), 8 data bits LSB first, one stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - A frame lasts 10*CLKS_PER_BIT cycles.
- Total transfer length from the first falling edge of UART_TX_O to Done is 2*Word_count*10*CLKS_PER_BIT cycles.
- Done is asserted the cycle after the last stop bit completes, and Busy falls in the same cycle.
- Serializer handshake: tx_valid/tx_ready.
  - A byte transfers when both are high on the same edge.
  - tx_ready is high only when the serializer is idle or during the final cycle of a stop bit; this final-cycle acceptance is what permits the gapless chaining.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit. The frame becomes 11 bits, and all frame-length figures above use 11 instead of 10.
- Undefined: plain 8N1, and no parity logic is generated.

Decomposition:
- Shared package sram_uart_tx_pkg:
  - tx_ctrl_state_type enum covering the S_TX_* states.
  - tx_ser_state_type enum: SER_IDLE, SER_START, SER_DATA, SER_PARITY, SER_STOP.
  - Localparams for the frame bit count (10 or 11).
- One sub-module, uart_tx_byte:
  - Contains the baud counter, bit counter and shift register.
  - Ports: clock, reset, tx_valid, tx_data[7:0], tx_ready, UART_TX_O.

Test Plan:
- Sim with CLKS_PER_BIT=8:
  - Stimulus: preload SRAM[100]=16'hA55A; Start with Start_address=100, Word_count=1.
  - Required: decoded bytes A5 then 5A; each bit 8 cycles wide; start bit begins at edge 5; Done occurs 160 cycles after the first falling edge.
- Back-to-back:
  - Stimulus: Word_count=3, SRAM[0..2]=16'h0102, 16'h0304, 16'h0506.
  - Required: bytes 01..06 in order; the line is never high for more than 8 cycles between frames; Done pulses exactly once.
- Wrap-around:
  - Stimulus: Start_address=18'h3FFFF, Word_count=2, SRAM[3FFFF]=16'hBEEF, SRAM[0]=16'hCAFE.
  - Required: bytes BE EF CA FE; SRAM_address sequence 3FFFF then 00000.
- Zero count and Start while busy:
  - Stimulus: Word_count=0.
  - Required: Done at edge 2 and no line activity.
  - Stimulus: a second Start mid-transfer with different parameters.
  - Required: output is unchanged from the original transfer.
- Reset mid-frame:
  - Stimulus: assert reset during data bit 4 of the first byte.
  - Required: UART_TX_O=1, Busy=0, SRAM_we_n=1 after the next edge; a new Start then transmits correctly from its first byte.
- With UART_TX_PARITY_EN defined:
  - Stimulus: byte 8'h07.
  - Required: parity bit = 1; frame is 88 cycles.
  - Stimulus: byte 8'h03.
  - Required: parity bit = 0.
